// File: rtl/cpu6_immdec_pipe.sv
// cpu6 decode-stage immediate decoder with pc+imm target, behind a two-entry
// valid/ready skid buffer so both the input and output sides are registered.
module cpu6_immdec_pipe #(
  parameter int XLEN      = 32,
  parameter int IMMTYPE_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [IMMTYPE_W-1:0] in_immtype,
  input  logic [XLEN-1:0]      in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_imm,
  output logic [XLEN-1:0]      out_target,
  output logic [XLEN-1:0]      out_pc,
  output logic                 out_illegal
);

  localparam logic [IMMTYPE_W-1:0] IMM_NONE  = IMMTYPE_W'(0);
  localparam logic [IMMTYPE_W-1:0] IMM_I     = IMMTYPE_W'(1);
  localparam logic [IMMTYPE_W-1:0] IMM_S     = IMMTYPE_W'(2);
  localparam logic [IMMTYPE_W-1:0] IMM_B     = IMMTYPE_W'(3);
  localparam logic [IMMTYPE_W-1:0] IMM_U     = IMMTYPE_W'(4);
  localparam logic [IMMTYPE_W-1:0] IMM_J     = IMMTYPE_W'(5);
  localparam logic [IMMTYPE_W-1:0] IMM_SHAMT = IMMTYPE_W'(6);
  localparam logic [IMMTYPE_W-1:0] IMM_CSR   = IMMTYPE_W'(7);

  // One stored entry: {illegal, pc, target, imm}
  localparam int DW = 3 * XLEN + 1;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } state_t;

  state_t          state_reg, state_next;
  logic            in_ready_reg;
  logic [DW-1:0]   out_reg, skid_reg;
  logic [DW-1:0]   dec_bundle;
  logic [XLEN-1:0] dec_imm, dec_target;
  logic            dec_illegal;
  logic            accept, emit;
  logic            load_out_in, load_out_skid, load_skid;

  // Opcode bits never carry immediate data.
  logic unused_opcode;
  assign unused_opcode = ^in_instr[6:0];

  // Immediate extraction; sign extension always comes from instr[31].
  always_comb begin
    dec_imm     = '0;
    dec_illegal = 1'b0;
    case (in_immtype)
      IMM_NONE: dec_imm = '0;
      IMM_I:    dec_imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
      IMM_S:    dec_imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      IMM_B:    dec_imm = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
      IMM_U:    dec_imm = {{(XLEN-32){in_instr[31]}}, in_instr[31:12], 12'b0};
      IMM_J:    dec_imm = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
      IMM_SHAMT: begin
        if (XLEN == 32) begin
          // Bit 25 set means a 6-bit shamt, which RV32 cannot encode.
          dec_imm     = {{(XLEN-5){1'b0}}, in_instr[24:20]};
          dec_illegal = in_instr[25];
        end else begin
          dec_imm = {{(XLEN-6){1'b0}}, in_instr[25:20]};
        end
      end
      IMM_CSR:  dec_imm = {{(XLEN-5){1'b0}}, in_instr[19:15]};
      default:  dec_imm = '0;
    endcase
  end

  assign dec_target = in_pc + dec_imm;
  assign dec_bundle = {dec_illegal, in_pc, dec_target, dec_imm};

  // Handshakes use only registered ready so flush never gates ready combinationally.
  assign accept = in_valid & in_ready_reg;
  assign emit   = (state_reg != ST_EMPTY) & out_ready;

  // Next-state and datapath load selects for the skid buffer.
  always_comb begin
    state_next    = state_reg;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            state_next  = ST_ONE;
            load_out_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && emit) begin
            load_out_in = 1'b1;
          end else if (accept) begin
            state_next = ST_TWO;
            load_skid  = 1'b1;
          end else if (emit) begin
            state_next = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (emit) begin
            state_next    = ST_ONE;
            load_out_skid = 1'b1;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  // State and registered ready; reset drops any in-flight data immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_EMPTY;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != ST_TWO);
    end
  end

  // Output entry: fresh decode or the older skid entry, preserving FIFO order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_reg <= '0;
    end else if (load_out_in) begin
      out_reg <= dec_bundle;
    end else if (load_out_skid) begin
      out_reg <= skid_reg;
    end
  end

  // Skid entry: catches a decode accepted while the output is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_reg <= '0;
    end else if (load_skid) begin
      skid_reg <= dec_bundle;
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = (state_reg != ST_EMPTY);
  assign out_imm     = out_reg[XLEN-1:0];
  assign out_target  = out_reg[2*XLEN-1:XLEN];
  assign out_pc      = out_reg[3*XLEN-1:2*XLEN];
  assign out_illegal = out_reg[DW-1];

endmodule

// File: tb/tb_cpu6_immdec_pipe.sv
// Scoreboard bench: one XLEN=32 and one XLEN=64 instance share stimulus.
module tb_cpu6_immdec_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [2:0]  in_immtype;
  logic [63:0] in_pc;

  logic        rdy32, vld32, ill32;
  logic [31:0] imm32, tgt32, pc32;
  logic        rdy64, vld64, ill64;
  logic [63:0] imm64, tgt64, pc64;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] imm32, tgt32;
    logic        ill32;
    logic [63:0] imm64, tgt64;
    logic        ill64;
    logic [63:0] pc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  cpu6_immdec_pipe #(.XLEN(32), .IMMTYPE_W(3)) u_dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr),
    .in_immtype(in_immtype), .in_pc(in_pc[31:0]),
    .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32),
    .out_target(tgt32), .out_pc(pc32), .out_illegal(ill32)
  );

  cpu6_immdec_pipe #(.XLEN(64), .IMMTYPE_W(3)) u_dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr),
    .in_immtype(in_immtype), .in_pc(in_pc),
    .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64),
    .out_target(tgt64), .out_pc(pc64), .out_illegal(ill64)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] i32, input logic [31:0] t32, input logic l32,
                              input logic [63:0] i64, input logic [63:0] t64, input logic l64,
                              input logic [63:0] pc);
    exp_t e;
    e.imm32 = i32; e.tgt32 = t32; e.ill32 = l32;
    e.imm64 = i64; e.tgt64 = t64; e.ill64 = l64;
    e.pc    = pc;
    return e;
  endfunction

  // Offer one instruction until accepted (bounded); expected result is queued on accept.
  task automatic send(input logic [31:0] instr, input logic [2:0] t, input logic [63:0] pc,
                      input exp_t e, output int cycles);
    bit acc;
    acc = 1'b0;
    cycles = 0;
    in_valid = 1'b1; in_instr = instr; in_immtype = t; in_pc = pc;
    while (!acc && cycles < 60) begin
      @(negedge clk);
      acc = rdy32 && !flush;
      @(posedge clk); #1;
      cycles++;
    end
    in_valid = 1'b0;
    if (acc) begin
      sb.push_back(e);
      check("latency_out_valid", {63'd0, vld32}, 64'd1);
    end else begin
      check("accept_timeout", 64'd0, 64'd1);
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (sb.size() != 0 && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: while output is valid it must equal the queue head (also proves
  // stability under stall); the head retires on handshake.
  always @(negedge clk) begin
    if (!reset && vld32) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {63'd0, vld32}, 64'd0);
      end else begin
        check("imm32",     {32'd0, imm32}, {32'd0, sb[0].imm32});
        check("target32",  {32'd0, tgt32}, {32'd0, sb[0].tgt32});
        check("pc32",      {32'd0, pc32},  {32'd0, sb[0].pc[31:0]});
        check("illegal32", {63'd0, ill32}, {63'd0, sb[0].ill32});
        check("valid64",   {63'd0, vld64}, 64'd1);
        check("imm64",     imm64, sb[0].imm64);
        check("target64",  tgt64, sb[0].tgt64);
        check("pc64",      pc64,  sb[0].pc);
        check("illegal64", {63'd0, ill64}, {63'd0, sb[0].ill64});
        if (out_ready) begin
          $display("emit pc=%h imm32=%h tgt32=%h ill32=%b imm64=%h tgt64=%h",
                   pc64, imm32, tgt32, ill32, imm64, tgt64);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic check_empty_ready(input string tag);
    check({tag, "_out_valid32"}, {63'd0, vld32}, 64'd0);
    check({tag, "_in_ready32"},  {63'd0, rdy32}, 64'd1);
    check({tag, "_out_valid64"}, {63'd0, vld64}, 64'd0);
    check({tag, "_in_ready64"},  {63'd0, rdy64}, 64'd1);
  endtask

  initial begin
    int cyc;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_immtype = '0; in_pc = '0;
    #1;
    check_empty_ready("reset");
    check("reset_imm32", {32'd0, imm32}, 64'd0);
    check("reset_target32", {32'd0, tgt32}, 64'd0);
    check("reset_pc64", pc64, 64'd0);
    check("reset_illegal32", {63'd0, ill32}, 64'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // Directed vectors, out_ready high: one accept per cycle.
    send(32'hFFF00093, 3'd1, 64'h100,
         mk(32'hFFFF_FFFF, 32'h0000_00FF, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFF, 0, 64'h100), cyc);
    check("throughput_I", 64'(cyc), 64'd1);
    send(32'hFE000EE3, 3'd3, 64'h100,
         mk(32'hFFFF_FFFC, 32'h0000_00FC, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFC, 0, 64'h100), cyc);
    check("throughput_B", 64'(cyc), 64'd1);
    send(32'h0010006F, 3'd5, 64'h1000,
         mk(32'h800, 32'h1800, 0, 64'h800, 64'h1800, 0, 64'h1000), cyc);
    send(32'h123450B7, 3'd4, 64'h2000,
         mk(32'h1234_5000, 32'h1234_7000, 0, 64'h1234_5000, 64'h1234_7000, 0, 64'h2000), cyc);
    send(32'h02009093, 3'd6, 64'h40,
         mk(32'h0, 32'h40, 1, 64'h20, 64'h60, 0, 64'h40), cyc);
    send(32'h01F09093, 3'd6, 64'h0,
         mk(32'h1F, 32'h1F, 0, 64'h1F, 64'h1F, 0, 64'h0), cyc);
    send(32'hFE112E23, 3'd2, 64'h300,
         mk(32'hFFFF_FFFC, 32'h2FC, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h2FC, 0, 64'h300), cyc);
    send(32'hFFFFD073, 3'd7, 64'h10,
         mk(32'h1F, 32'h2F, 0, 64'h1F, 64'h2F, 0, 64'h10), cyc);
    send(32'hFFFFFFFF, 3'd0, 64'hABC,
         mk(32'h0, 32'hABC, 0, 64'h0, 64'hABC, 0, 64'hABC), cyc);
    send(32'h7FF00093, 3'd1, 64'hFFFF_FFFF,
         mk(32'h7FF, 32'h7FE, 0, 64'h7FF, 64'h1_0000_07FE, 0, 64'hFFFF_FFFF), cyc);
    check("throughput_last", 64'(cyc), 64'd1);
    drain();

    // Backpressure: four items, only two fit until out_ready rises.
    out_ready = 1'b0;
    fork
      begin
        send(32'h00100093, 3'd1, 64'h10, mk(32'h1, 32'h11, 0, 64'h1, 64'h11, 0, 64'h10), cyc);
        send(32'h00200093, 3'd1, 64'h20, mk(32'h2, 32'h22, 0, 64'h2, 64'h22, 0, 64'h20), cyc);
        send(32'h00300093, 3'd1, 64'h30, mk(32'h3, 32'h33, 0, 64'h3, 64'h33, 0, 64'h30), cyc);
        send(32'h00400093, 3'd1, 64'h40, mk(32'h4, 32'h44, 0, 64'h4, 64'h44, 0, 64'h40), cyc);
      end
      begin
        repeat (5) @(negedge clk);
        check("bp_in_ready32", {63'd0, rdy32}, 64'd0);
        check("bp_sb_depth", 64'(sb.size()), 64'd2);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with both entries full.
    out_ready = 1'b0;
    send(32'h00500093, 3'd1, 64'h50, mk(32'h5, 32'h55, 0, 64'h5, 64'h55, 0, 64'h50), cyc);
    send(32'h00600093, 3'd1, 64'h60, mk(32'h6, 32'h66, 0, 64'h6, 64'h66, 0, 64'h60), cyc);
    check("pre_reset_in_ready", {63'd0, rdy32}, 64'd0);
    #2 reset = 1'b1;
    #1;
    check_empty_ready("async_reset");
    check("async_reset_imm32", {32'd0, imm32}, 64'd0);
    sb.delete();
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h00700093, 3'd1, 64'h70, mk(32'h7, 32'h77, 0, 64'h7, 64'h77, 0, 64'h70), cyc);
    drain();

    // Flush together with an accept while one entry is held.
    out_ready = 1'b0;
    send(32'h00800093, 3'd1, 64'h80, mk(32'h8, 32'h88, 0, 64'h8, 64'h88, 0, 64'h80), cyc);
    in_valid = 1'b1; in_instr = 32'h0AA00093; in_immtype = 3'd1; in_pc = 64'hAA0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    check_empty_ready("flush_one");

    // Flush with both entries full and input offered.
    send(32'h00900093, 3'd1, 64'h90, mk(32'h9, 32'h99, 0, 64'h9, 64'h99, 0, 64'h90), cyc);
    send(32'h00A00093, 3'd1, 64'hA0, mk(32'hA, 32'hAA, 0, 64'hA, 64'hAA, 0, 64'hA0), cyc);
    in_valid = 1'b1; in_instr = 32'h0BB00093; in_immtype = 3'd1; in_pc = 64'hBB0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    check_empty_ready("flush_two");

    // Only the post-flush item may emerge.
    out_ready = 1'b1;
    send(32'h00C00093, 3'd1, 64'hC0, mk(32'hC, 32'hCC, 0, 64'hC, 64'hCC, 0, 64'hC0), cyc);
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("final_out_valid", {63'd0, vld32}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu6_immdec_pipe.md
Name: cpu6_immdec_pipe

Overview:
Parametrised, registered immediate decoder for the cpu6 decode stage. It supports all RV32/RV64 immediate formats (I, S, B, U, J, shift-amount, CSR zimm) and computes the PC-relative target `pc + imm` alongside the immediate. It sits between fetch/decode and the execute stage behind a valid/ready skid buffer, so both its input and output are fully registered and sustain one instruction per cycle.

Parameters:
- XLEN, 32, datapath width; legal values 32 and 64.
- IMMTYPE_W, 3, width of the immtype select.

Ports:
- clk, input, 1, core clock; all state updates on rising edge.
- reset, input, 1, asynchronous active-high reset.
- flush, input, 1, synchronous pipeline kill.
- in_valid, input, 1, upstream offers an instruction.
- in_ready, output, 1, block can accept; driven directly from a flop.
- in_instr, input, 32, raw instruction word.
- in_immtype, input, IMMTYPE_W, immediate format select.
- in_pc, input, XLEN, PC of in_instr.
- out_valid, output, 1, output holds a decoded result.
- out_ready, input, 1, downstream accepts.
- out_imm, output, XLEN, sign- or zero-extended immediate.
- out_target, output, XLEN, out_pc + out_imm, modulo 2^XLEN.
- out_pc, output, XLEN, PC passed through.
- out_illegal, output, 1, immediate-field encoding is illegal for this XLEN.

Behaviour:
- Reset: asynchronous, active-high. While reset is high: in_ready=1, out_valid=0, out_imm=0, out_target=0, out_pc=0, out_illegal=0, skid buffer empty. Applies equally mid-transfer; any in-flight data is dropped.
- immtype encoding and decode:
  - 0 NONE → imm=0
  - 1 I → sext(instr[31:20])
  - 2 S → sext({instr[31:25], instr[11:7]})
  - 3 B → sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
  - 4 U → sext({instr[31:12], 12'b0})
  - 5 J → sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})
  - 6 SHAMT → zext(instr[24:20]) when XLEN=32; zext(instr[25:20]) when XLEN=64
  - 7 CSR zimm → zext(instr[19:15])
- Sign extension always uses instr[31].
- Illegal flag: out_illegal=1 only for SHAMT with XLEN=32 and instr[25]=1. The imm for that case is still zext(instr[24:20]). The flag is 0 for all other types.
- Target: an XLEN-bit adder computes `pc + imm` for every type, including NONE (target=pc). Carry out is discarded.
- Decode and add are performed combinationally on the input side. The results are captured into the output register or the skid register.
- Pipeline: two-entry skid buffer.
  - States: EMPTY (out_valid=0), ONE (out reg full, skid empty), TWO (both full).
  - in_ready = skid empty (state ≠ TWO), registered.
  - Accept = in_valid & in_ready; emit = out_valid & out_ready.
  - EMPTY + accept → ONE.
  - ONE + accept, no emit → TWO (new item to skid).
  - ONE + accept + emit → ONE (new item to out reg).
  - ONE + emit, no accept → EMPTY.
  - TWO + emit → ONE (skid moves to out reg); in_ready rises next cycle.
  - TWO ignores in_valid.
- Latency: an accepted instruction is visible on the out_* ports the cycle after acceptance. Throughput is 1/cycle when out_ready is held high.
- Output data is held stable while out_valid=1 and out_ready=0 (AXI-style; no change until handshake).
- Ordering: strict FIFO; the skid entry never overtakes the output entry.
- flush: next state is EMPTY and in_ready=1. Flush beats a simultaneous accept: the input is dropped and in_ready is not masked combinationally. Output data registers may retain stale values, but out_valid=0.
- Upstream must hold in_* stable while in_valid=1 and in_ready=0. The block does not check this.

Test Plan:
- Reset asserted mid-stream with both entries full → out_valid=0 and in_ready=1 asynchronously, before the next clk edge; after release the first accepted item emerges one cycle later.
- I-type 0xFFF00093, pc=0x0000_0100, out_ready=1 → next cycle out_imm=0xFFFF_FFFF, out_target=0x0000_00FF, out_illegal=0.
- B-type 0xFE000EE3, pc=0x100 → out_imm=0xFFFF_FFFC, target=0x0000_00FC. J-type 0x0010006F, pc=0x1000 → imm=0x800, target=0x1800. U-type 0x123450B7 → imm=0x1234_5000.
- XLEN=32, SHAMT 0x02009093 → out_illegal=1, out_imm=0. Same word with XLEN=64 → out_illegal=0, out_imm=0x20.
- Backpressure: stream 4 items with out_ready=0 → items 1–2 accepted, in_ready=0 from the cycle after item 2, out_* stable. Raise out_ready → items 1–4 emerge in order with no loss or duplication.
- flush asserted in the same cycle as an accept, with state TWO → next cycle out_valid=0, in_ready=1; the accepted item never appears.
